// File: rtl/pipeline_ctrl.sv
// Central stall/flush control for the 5-stage core: load-use, redirect, imem and dmem wait handling.
// Optional perf counters are enabled by defining PIPELINE_CTRL_PERF_EN.
module pipeline_ctrl #(
  parameter int unsigned WAIT_TIMEOUT = 255,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd_reg,
  input  logic             mem_redirect,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             imem_ready,
  output logic             pc_wren,
  output logic             fd_wren,
  output logic             de_wren,
  output logic             em_wren,
  output logic             mw_wren,
  output logic             fd_flush,
  output logic             de_flush,
  output logic             em_flush,
  output logic             mw_flush,
  output logic             dmem_abort,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {BOOT, RUN, MEM_WAIT} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(WAIT_TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic             dmem_pending;
  logic             load_use;

  assign dmem_pending = dmem_req && !dmem_ready;
  assign load_use = ex_mem_read && (ex_rd_reg != 5'd0) &&
                    ((id_uses_rs && (id_rs == ex_rd_reg)) ||
                     (id_uses_rt && (id_rt == ex_rd_reg)));

  always_comb begin
    pc_wren       = 1'b0;
    fd_wren       = 1'b0;
    de_wren       = 1'b0;
    em_wren       = 1'b0;
    mw_wren       = 1'b0;
    fd_flush      = 1'b0;
    de_flush      = 1'b0;
    em_flush      = 1'b0;
    mw_flush      = 1'b0;
    dmem_abort    = 1'b0;
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    // Outputs are forced quiet while reset is held, regardless of state.
    if (reset_n) begin
      if (state_q == BOOT) begin
        {fd_wren, de_wren, em_wren, mw_wren}     = 4'hf;
        {fd_flush, de_flush, em_flush, mw_flush} = 4'hf;
        state_d    = RUN;
        wait_cnt_d = '0;
      end else begin
        state_d    = RUN;
        wait_cnt_d = '0;
        if (dmem_pending && (wait_cnt_q < TIMEOUT_C)) begin
          wait_cnt_d = wait_cnt_q + ONE_C;
          state_d    = MEM_WAIT;
        end else if (dmem_pending) begin
          {pc_wren, fd_wren, de_wren, em_wren, mw_wren} = 5'h1f;
          mw_flush      = 1'b1;
          dmem_abort    = 1'b1;
          mem_timeout_d = 1'b1;
        end else if (mem_redirect) begin
          {pc_wren, fd_wren, de_wren, em_wren, mw_wren} = 5'h1f;
          {fd_flush, de_flush, em_flush}                = 3'h7;
        end else if (load_use) begin
          {de_wren, em_wren, mw_wren} = 3'h7;
          de_flush = 1'b1;
        end else if (!imem_ready) begin
          {fd_wren, de_wren, em_wren, mw_wren} = 4'hf;
          fd_flush = 1'b1;
        end else begin
          {pc_wren, fd_wren, de_wren, em_wren, mw_wren} = 5'h1f;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= BOOT;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign mem_timeout = mem_timeout_q;

`ifdef PIPELINE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (reset_n && (state_q != BOOT) && !pc_wren && (stall_count_q != '1))
      stall_count_d = stall_count_q + ONE_C;
    // Outside BOOT, em_flush without mw_flush only happens on a redirect.
    if (reset_n && (state_q != BOOT) && em_flush && !mw_flush && (flush_count_q != '1))
      flush_count_d = flush_count_q + ONE_C;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;
`else
  assign stall_count = '0;
  assign flush_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: vector table plus hand sequences for dmem wait, timeout and async reset.
module tb_pipeline_ctrl;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic reset_n;
  logic [4:0] id_rs, id_rt, ex_rd_reg;
  logic id_uses_rs, id_uses_rt, ex_mem_read, mem_redirect, dmem_req, dmem_ready, imem_ready;
  logic pc_wren, fd_wren, de_wren, em_wren, mw_wren;
  logic fd_flush, de_flush, em_flush, mw_flush, dmem_abort, mem_timeout;
  logic [CNT_W-1:0] stall_count, flush_count;

  pipeline_ctrl #(.WAIT_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rd_reg(ex_rd_reg), .mem_redirect(mem_redirect),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .imem_ready(imem_ready),
    .pc_wren(pc_wren), .fd_wren(fd_wren), .de_wren(de_wren), .em_wren(em_wren), .mw_wren(mw_wren),
    .fd_flush(fd_flush), .de_flush(de_flush), .em_flush(em_flush), .mw_flush(mw_flush),
    .dmem_abort(dmem_abort), .mem_timeout(mem_timeout),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  // {pc,fd,de,em,mw wren, fd,de,em,mw flush, dmem_abort, mem_timeout}
  localparam logic [10:0] E_ZERO = 11'b00000_0000_00;
  localparam logic [10:0] E_BOOT = 11'b01111_1111_00;
  localparam logic [10:0] E_NORM = 11'b11111_0000_00;
  localparam logic [10:0] E_LU   = 11'b00111_0100_00;
  localparam logic [10:0] E_IS   = 11'b01111_1000_00;
  localparam logic [10:0] E_RD   = 11'b11111_1110_00;
  localparam logic [10:0] E_TO   = 11'b11111_0001_10;

  typedef struct {
    logic [4:0] rs; logic [4:0] rt; logic urs; logic urt; logic exr; logic [4:0] exrd;
    logic redir; logic dreq; logic drdy; logic irdy; logic [10:0] exp;
  } vec_t;

  vec_t tbl[12];
  vec_t idle, v;
  logic [10:0] act;
  logic [10:0] exp_q[$];
  string name_q[$];
  logic to_flag;
  int checks = 0, failures = 0;
  int stall_exp = 0, flush_exp = 0;

  assign act = {pc_wren, fd_wren, de_wren, em_wren, mw_wren,
                fd_flush, de_flush, em_flush, mw_flush, dmem_abort, mem_timeout};

  task automatic cmp(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %b expected %b", nm, a, e);
    end
  endtask

  task automatic drv(input vec_t x);
    id_rs = x.rs; id_rt = x.rt; id_uses_rs = x.urs; id_uses_rt = x.urt;
    ex_mem_read = x.exr; ex_rd_reg = x.exrd; mem_redirect = x.redir;
    dmem_req = x.dreq; dmem_ready = x.drdy; imem_ready = x.irdy;
  endtask

  // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
  task automatic step(input string nm, input logic [10:0] e, input bit counted);
    logic [10:0] ex;
    string n;
    exp_q.push_back(e | {10'b0, to_flag});
    name_q.push_back(nm);
    if (counted && !e[10]) stall_exp++;
    if (counted && e == E_RD) flush_exp++;
    @(negedge clk);
    ex = exp_q.pop_front();
    n = name_q.pop_front();
    cmp(n, {21'b0, act}, {21'b0, ex});
    @(posedge clk); #1;
  endtask

  task automatic check_perf(input string nm);
`ifdef PIPELINE_CTRL_PERF_EN
    cmp({nm, "_stall_count"}, 32'(stall_count), 32'(stall_exp));
    cmp({nm, "_flush_count"}, 32'(flush_count), 32'(flush_exp));
`else
    cmp({nm, "_stall_count"}, 32'(stall_count), 32'd0);
    cmp({nm, "_flush_count"}, 32'(flush_count), 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle = '{rs:5'd0, rt:5'd0, urs:1'b0, urt:1'b0, exr:1'b0, exrd:5'd0,
             redir:1'b0, dreq:1'b0, drdy:1'b1, irdy:1'b1, exp:E_NORM};
    for (int i = 0; i < 12; i++) tbl[i] = idle;
    tbl[1].rs = 5'd5; tbl[1].urs = 1'b1; tbl[1].exr = 1'b1; tbl[1].exrd = 5'd5; tbl[1].exp = E_LU;
    tbl[2].urs = 1'b1; tbl[2].exr = 1'b1;
    tbl[3].rt = 5'd7; tbl[3].urt = 1'b1; tbl[3].exr = 1'b1; tbl[3].exrd = 5'd7; tbl[3].exp = E_LU;
    tbl[4].rt = 5'd7; tbl[4].rs = 5'd3; tbl[4].urs = 1'b1; tbl[4].exr = 1'b1; tbl[4].exrd = 5'd7;
    tbl[5].irdy = 1'b0; tbl[5].exp = E_IS;
    tbl[6].rs = 5'd5; tbl[6].urs = 1'b1; tbl[6].exr = 1'b1; tbl[6].exrd = 5'd5;
    tbl[6].redir = 1'b1; tbl[6].irdy = 1'b0; tbl[6].exp = E_RD;
    tbl[7].dreq = 1'b1;
    tbl[8].dreq = 1'b1; tbl[8].drdy = 1'b0; tbl[8].redir = 1'b1; tbl[8].exp = E_ZERO;
    tbl[9].dreq = 1'b1; tbl[9].redir = 1'b1; tbl[9].exp = E_RD;
    tbl[10].rs = 5'd9; tbl[10].urs = 1'b1; tbl[10].exr = 1'b1; tbl[10].exrd = 5'd9;
    tbl[10].irdy = 1'b0; tbl[10].exp = E_LU;
    tbl[11].rs = 5'd9; tbl[11].urs = 1'b1; tbl[11].exrd = 5'd9;

    to_flag = 1'b0;
    reset_n = 1'b0;
    drv(idle);
    #3;
    cmp("reset_outputs", {21'b0, act}, {21'b0, E_ZERO});
    check_perf("reset");
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    step("boot_cycle", E_BOOT, 1'b0);
    step("first_run", E_NORM, 1'b1);

    for (int i = 0; i < 12; i++) begin
      drv(tbl[i]);
      step($sformatf("vec%0d", i), tbl[i].exp, 1'b1);
    end
    check_perf("table");

    // dmem wait for three cycles, then completion
    v = idle; v.dreq = 1'b1; v.drdy = 1'b0;
    drv(v);
    for (int i = 0; i < 3; i++) step($sformatf("dwait%0d", i), E_ZERO, 1'b1);
    v.drdy = 1'b1; drv(v);
    step("dwait_done", E_NORM, 1'b1);
    check_perf("dwait");

    // dmem never ready: four frozen cycles, then abort
    v = idle; v.dreq = 1'b1; v.drdy = 1'b0;
    drv(v);
    for (int i = 0; i < 4; i++) step($sformatf("to_wait%0d", i), E_ZERO, 1'b1);
    step("timeout_abort", E_TO, 1'b1);
    to_flag = 1'b1;
    drv(idle);
    step("timeout_sticky0", E_NORM, 1'b1);
    step("timeout_sticky1", E_NORM, 1'b1);
    check_perf("timeout");

    // enter MEM_WAIT, then assert reset mid-cycle
    drv(v);
    step("pre_reset_wait", E_ZERO, 1'b1);
    #2;
    reset_n = 1'b0;
    to_flag = 1'b0;
    stall_exp = 0; flush_exp = 0;
    #1;
    cmp("async_reset_outputs", {21'b0, act}, {21'b0, E_ZERO});
    check_perf("async_reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    drv(v);
    step("boot_again", E_BOOT, 1'b0);
    for (int i = 0; i < 4; i++) step($sformatf("post_reset_wait%0d", i), E_ZERO, 1'b1);
    step("post_reset_abort", E_TO, 1'b1);
    to_flag = 1'b1;
    drv(idle);
    step("post_reset_norm", E_NORM, 1'b1);
    check_perf("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central pipeline control for the 5-stage core. Drives the write-enable and bubble-insert (flush) inputs of the PC and the FD/DE/EM/MW stage registers. Handles four cases: load-use hazards, taken branches/jumps resolved at the EM output, instruction-memory not-ready, and multi-cycle data-memory waits with a timeout.
Sits beside the datapath; reads decoded fields from the ID, EX and MEM stages.

Parameters:
WAIT_TIMEOUT, 255, max consecutive dmem wait cycles before abort (1..65535)
CNT_W, 16, width of wait counter and perf counters

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
id_rs  input  5  source reg A of instruction in ID
id_rt  input  5  source reg B of instruction in ID
id_uses_rs  input  1  ID instruction reads id_rs
id_uses_rt  input  1  ID instruction reads id_rt
ex_mem_read  input  1  DE-register dec_mem_read (load in EX)
ex_rd_reg  input  5  DE-register rd_reg
mem_redirect  input  1  EM-register (dec_branch & alu_result_zero) | dec_jmp
dmem_req  input  1  EM-register dec_mem_read | dec_mem_write
dmem_ready  input  1  data memory completes access this cycle
imem_ready  input  1  instruction memory word valid this cycle
pc_wren, fd_wren, de_wren, em_wren, mw_wren  output  1 each  stage write enables
fd_flush, de_flush, em_flush, mw_flush  output  1 each  load bubble (all control fields 0) at this edge
dmem_abort  output  1  one-cycle pulse: drop outstanding data access
mem_timeout  output  1  sticky timeout flag
stall_count  output  CNT_W  stall cycles (optional feature)
flush_count  output  CNT_W  redirect events (optional feature)

Behaviour:
- All outputs are combinational from state, wait counter and inputs. Only state, wait_cnt, mem_timeout and the perf counters are flops.
- Reset (reset_n=0, async): state=BOOT, wait_cnt=0, mem_timeout=0, counters=0. While reset_n=0, all wren=0, all flush=0, dmem_abort=0.
- Any flush is always asserted together with its wren=1.
- BOOT: lasts exactly one cycle after reset release. All wren=1, all flush=1, pc_wren=0 (PC stays 0). Then go to RUN.
- RUN/MEM_WAIT: evaluate conditions in priority order; the first match wins.
  1. DWAIT (dmem_req & !dmem_ready & wait_cnt<WAIT_TIMEOUT): all wren=0. wait_cnt++. state=MEM_WAIT.
  2. TIMEOUT (dmem_req & !dmem_ready & wait_cnt==WAIT_TIMEOUT): dmem_abort=1, mem_timeout<=1. All wren=1, mw_flush=1 (access dropped, no writeback). wait_cnt<=0, state=RUN.
  3. REDIRECT (mem_redirect): all wren=1. fd_flush=de_flush=em_flush=1. PC loads the branch target.
  4. LOADUSE (ex_mem_read & ex_rd_reg!=0 & ((id_uses_rs & id_rs==ex_rd_reg) | (id_uses_rt & id_rt==ex_rd_reg))): pc_wren=fd_wren=0. de_wren=1, de_flush=1. em_wren=mw_wren=1.
  5. ISTALL (!imem_ready): pc_wren=0. fd_wren=1, fd_flush=1. Other stages wren=1.
  6. Otherwise: all wren=1, no flush.
- Any cycle other than DWAIT clears wait_cnt to 0 and sets state=RUN.
- Latency: all decisions take effect at the same clock edge; no added pipeline delay.
- Register 0 never causes a load-use stall.
- A load-use stall lasts exactly one cycle, because the bubble clears ex_mem_read.
- REDIRECT overrides LOADUSE and ISTALL in the same cycle, since the ID instruction is discarded anyway.
- mem_timeout is cleared only by reset.
- wait_cnt never exceeds WAIT_TIMEOUT.

Optional Feature:
PIPELINE_CTRL_PERF_EN
- Defined:
  - stall_count increments, saturating at all-ones, on every RUN/MEM_WAIT cycle in which pc_wren=0.
  - flush_count increments, saturating, on every REDIRECT cycle.
  - Both reset to 0.
- Undefined: stall_count and flush_count are tied to 0 and no counter flops exist.

Test Plan:
- Reset release -> cycle 1: all wren=1 except pc_wren=0, all flush=1. Cycle 2: all wren=1, flush=0.
- ex_mem_read=1, ex_rd_reg=5, id_rs=5, id_uses_rs=1 -> one cycle with pc_wren=fd_wren=0 and de_flush=1. Repeat with ex_rd_reg=0 -> no stall.
- dmem_req=1, dmem_ready=0 for 3 cycles, then 1 -> 3 cycles all wren=0, then normal. stall_count=3 with PERF_EN.
- WAIT_TIMEOUT=4, dmem_ready held 0 -> 4 frozen cycles, 5th cycle dmem_abort=1 and mw_flush=1, mem_timeout stays 1 until reset.
- mem_redirect=1 together with a load-use match and imem_ready=0 -> fd/de/em_flush=1, pc_wren=1, flush_count=1.
- Assert reset_n=0 mid MEM_WAIT -> outputs go to reset values immediately (async), wait_cnt=0, BOOT on release.
